// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field definitions, FSM states and
// operand-class helpers used by the sequential FP divider.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    // Signed exponent width: holds ea - eb + BIAS for any pair of fields.
    localparam int E_W     = 10;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_t;

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    function automatic logic is_zero(input fp_t x);
        return x.exp == '0;
    endfunction

    function automatic logic is_inf(input fp_t x);
        return x.exp == '1;
    endfunction

    function automatic fp_t mk_inf(input logic s);
        fp_t r;
        r.sign = s;
        r.exp  = '1;
        r.man  = '0;
        return r;
    endfunction

    function automatic fp_t mk_zero(input logic s);
        fp_t r;
        r.sign = s;
        r.exp  = '0;
        r.man  = '0;
        return r;
    endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// Start/done handshake and operand/result bundle of the sequential divider.
interface fp_div_seq_if;

    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    logic        div_by_zero;

    modport master (output start, a, b,
                    input  busy, done, result, ovf, unf, div_by_zero);
    modport slave  (input  start, a, b,
                    output busy, done, result, ovf, unf, div_by_zero);

endinterface

// File: rtl/fp_div_exp_sub.sv
// Quotient exponent: ea - eb + BIAS as a 10-bit signed value, plus the
// one-lower variant used when the mantissa quotient needs a left shift.
module fp_div_exp_sub
    import fp_pkg::*;
(
    input  logic [EXP_W-1:0]      ea,
    input  logic [EXP_W-1:0]      eb,
    output logic signed [E_W-1:0] e,
    output logic signed [E_W-1:0] e_m1
);

    localparam logic signed [E_W-1:0] BIAS_S = E_W'(BIAS);
    localparam logic signed [E_W-1:0] ONE_S  = E_W'(1);

    assign e    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;
    assign e_m1 = e - ONE_S;

endmodule

// File: rtl/fp_div_seq.sv
// Sequential single-precision divider, restoring mantissa division at one
// quotient bit per cycle. Define FP_DIV_ROUND_EN for round-to-nearest-even.
module fp_div_seq
    import fp_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    fp_div_seq_if.slave  bus
);

`ifdef FP_DIV_ROUND_EN
    localparam int Q_W = MAN_W + 3;
`else
    localparam int Q_W = MAN_W + 2;
`endif
    localparam int SIG_W = MAN_W + 1;
    localparam logic [4:0] LAST = 5'(Q_W - 1);
    localparam logic signed [E_W-1:0] EXP_MAX_S = E_W'(EXP_MAX);
    localparam logic signed [E_W-1:0] ZERO_S    = '0;

    fp_t    fa, fb;
    logic   sign_in;
    state_t state;
    logic [4:0] cnt;

    logic signed [E_W-1:0] e_new, e_m1_new, e_p0, e_m1_p0;
    logic                  sign_p0;
    logic [SIG_W-1:0]      mb_p0;
    logic [SIG_W:0]        rem, rem_diff, rem_next;
    logic [Q_W-1:0]        quo;
    logic                  qbit;

    logic signed [E_W-1:0] exp_n;
    logic [MAN_W-1:0]      man_n;

    assign fa      = bus.a;
    assign fb      = bus.b;
    assign sign_in = fa.sign ^ fb.sign;

    fp_div_exp_sub u_exp (
        .ea   (fa.exp),
        .eb   (fb.exp),
        .e    (e_new),
        .e_m1 (e_m1_new)
    );

    function automatic logic [SIG_W:0] round_rne(input logic [SIG_W-1:0] sig,
                                                 input logic guard, input logic sticky);
        return {1'b0, sig} + (SIG_W+1)'(guard & (sticky | sig[0]));
    endfunction

    // Returns {ovf, unf, result}.
    function automatic logic [33:0] saturate(input logic s, input logic signed [E_W-1:0] ex,
                                             input logic [MAN_W-1:0] man);
        if (ex >= EXP_MAX_S) return {2'b10, mk_inf(s)};
        if (ex <= ZERO_S)    return {2'b01, mk_zero(s)};
        return {2'b00, s, ex[EXP_W-1:0], man};
    endfunction

    assign qbit     = rem >= {1'b0, mb_p0};
    assign rem_diff = qbit ? rem - {1'b0, mb_p0} : rem;
    assign rem_next = rem_diff << 1;

`ifdef FP_DIV_ROUND_EN
    logic [SIG_W-1:0]      sig;
    logic                  guard, sticky;
    logic [SIG_W:0]        sig_r;
    logic signed [E_W-1:0] exp_pre;

    always_comb begin
        if (quo[Q_W-1]) begin
            sig     = quo[Q_W-1:2];
            guard   = quo[1];
            sticky  = quo[0] | (rem != '0);
            exp_pre = e_p0;
        end else begin
            sig     = quo[Q_W-2:1];
            guard   = quo[0];
            sticky  = rem != '0;
            exp_pre = e_m1_p0;
        end
        sig_r = round_rne(sig, guard, sticky);
        man_n = sig_r[MAN_W-1:0];
        // Top two bits are 01 normally, 10 on rounding carry-out: adds 0 or 1.
        exp_n = exp_pre + $signed({{(E_W-2){1'b0}}, sig_r[SIG_W:MAN_W]}) - E_W'(1);
    end
`else
    always_comb begin
        if (quo[Q_W-1]) begin
            man_n = quo[Q_W-2:1];
            exp_n = e_p0;
        end else begin
            man_n = quo[Q_W-3:0];
            exp_n = e_m1_p0;
        end
    end
`endif

    // Operand latch at accept, then one restoring step per DIV cycle.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            rem     <= {2'b01, fa.man};
            mb_p0   <= {1'b1, fb.man};
            quo     <= '0;
            e_p0    <= e_new;
            e_m1_p0 <= e_m1_new;
            sign_p0 <= sign_in;
        end else if (state == DIV) begin
            rem <= rem_next;
            quo <= {quo[Q_W-2:0], qbit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.result      <= '0;
            bus.ovf         <= 1'b0;
            bus.unf         <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    bus.ovf         <= 1'b0;
                    bus.unf         <= 1'b0;
                    bus.div_by_zero <= 1'b0;
                    cnt             <= '0;
                    if (is_zero(fb)) begin
                        bus.div_by_zero <= 1'b1;
                        bus.result      <= mk_inf(sign_in);
                        bus.done        <= 1'b1;
                        state           <= DONE;
                    end else if (is_inf(fa) || is_inf(fb)) begin
                        bus.ovf    <= 1'b1;
                        bus.result <= mk_inf(sign_in);
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else if (is_zero(fa)) begin
                        bus.result <= mk_zero(sign_in);
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else begin
                        bus.busy <= 1'b1;
                        state    <= DIV;
                    end
                end
                DIV: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) state <= NORM;
                end
                NORM: begin
                    {bus.ovf, bus.unf, bus.result} <= saturate(sign_p0, exp_n, man_n);
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
